// File: rtl/main_memory_if.sv
// Bus bundle between the processing block (master) and main memory (slave).
interface main_memory_if #(
  parameter int DATA_W = 512
);
  logic              load_ctrl;
  logic [15:0]       load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              write_ctrl;
  logic [15:0]       write_addr;
  logic [DATA_W-1:0] write_data;
  logic              init_en;
  logic [15:0]       init_addr;
  logic [DATA_W-1:0] init_data;
  logic [31:0]       load_count;
  logic [31:0]       write_count;
  logic              addr_error;
  logic              init_collision;

  modport master (
    output load_ctrl, load_addr, write_ctrl, write_addr, write_data,
           init_en, init_addr, init_data,
    input  load_data, load_valid, load_count, write_count,
           addr_error, init_collision
  );

  modport slave (
    input  load_ctrl, load_addr, write_ctrl, write_addr, write_data,
           init_en, init_addr, init_data,
    output load_data, load_valid, load_count, write_count,
           addr_error, init_collision
  );
endinterface

// File: rtl/main_memory.sv
// Main-memory responder: DEPTH x DATA_W array, one write (or init) and one
// load per cycle, write-first bypass, fixed LATENCY registered load response.
module main_memory #(
  parameter int LANES   = 16,
  parameter int DATA_W  = LANES * 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input logic         clock,
  input logic         reset,
  main_memory_if.slave bus
);

  localparam int          ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              init_in_range;
  logic              ld_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] capture;

  logic              vld_p  [LATENCY];
  logic [DATA_W-1:0] data_p [LATENCY];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Decode the single write port (write_ctrl beats init) and form the
  // load word with the same-edge write already applied.
  always_comb begin
    wr_in_range   = {1'b0, bus.write_addr} < DEPTH_L;
    init_in_range = {1'b0, bus.init_addr} < DEPTH_L;
    ld_in_range   = {1'b0, bus.load_addr} < DEPTH_L;
    mem_we        = bus.write_ctrl ? wr_in_range : (bus.init_en && init_in_range);
    mem_waddr     = bus.write_ctrl ? bus.write_addr[ADDR_W-1:0] : bus.init_addr[ADDR_W-1:0];
    mem_wdata     = bus.write_ctrl ? bus.write_data : bus.init_data;
    capture       = '0;
    if (ld_in_range) begin
      if (mem_we && (mem_waddr == bus.load_addr[ADDR_W-1:0]))
        capture = mem_wdata;
      else
        capture = mem[bus.load_addr[ADDR_W-1:0]];
    end
  end

  // Storage array: never cleared, so contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Request counters and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.load_count     <= '0;
      bus.write_count    <= '0;
      bus.addr_error     <= 1'b0;
      bus.init_collision <= 1'b0;
    end else begin
      if (bus.load_ctrl)
        bus.load_count <= sat_inc(bus.load_count);
      if (bus.write_ctrl)
        bus.write_count <= sat_inc(bus.write_count);
      if ((bus.load_ctrl && !ld_in_range) ||
          (bus.write_ctrl && !wr_in_range) ||
          (!bus.write_ctrl && bus.init_en && !init_in_range))
        bus.addr_error <= 1'b1;
      if (bus.write_ctrl && bus.init_en)
        bus.init_collision <= 1'b1;
    end
  end

  // Response pipeline: data stages only advance with a valid response so the
  // output word holds its last value between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= bus.load_ctrl;
      if (bus.load_ctrl)
        data_p[0] <= capture;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1])
          data_p[i] <= data_p[i-1];
      end
    end
  end

  assign bus.load_valid = vld_p[LATENCY-1];
  assign bus.load_data  = data_p[LATENCY-1];

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: three instances (LATENCY 1, 2, 3) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_main_memory;

  localparam int DW = 512;
  localparam int ND = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_ctrl = 1'b0;
  logic [15:0]   load_addr = '0;
  logic          write_ctrl = 1'b0;
  logic [15:0]   write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          init_en = 1'b0;
  logic [15:0]   init_addr = '0;
  logic [DW-1:0] init_data = '0;

  logic          dv [ND];
  logic [DW-1:0] dd [ND];
  logic [31:0]   dlc [ND];
  logic [31:0]   dwc [ND];
  logic          dae [ND];
  logic          dic [ND];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  main_memory_if #(.DATA_W(DW)) ifs [ND] ();

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign ifs[g].load_ctrl  = load_ctrl;
    assign ifs[g].load_addr  = load_addr;
    assign ifs[g].write_ctrl = write_ctrl;
    assign ifs[g].write_addr = write_addr;
    assign ifs[g].write_data = write_data;
    assign ifs[g].init_en    = init_en;
    assign ifs[g].init_addr  = init_addr;
    assign ifs[g].init_data  = init_data;
    assign dv[g]  = ifs[g].load_valid;
    assign dd[g]  = ifs[g].load_data;
    assign dlc[g] = ifs[g].load_count;
    assign dwc[g] = ifs[g].write_count;
    assign dae[g] = ifs[g].addr_error;
    assign dic[g] = ifs[g].init_collision;

    main_memory #(.LANES(16), .DATA_W(DW), .DEPTH(256), .LATENCY(g + 1)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifs[g])
    );
  end

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [256];
  logic [31:0]   m_lc = '0;
  logic [31:0]   m_wc = '0;
  logic          m_ae = 1'b0;
  logic          m_ic = 1'b0;
  int            edge_n = 0;
  bit            live = 1'b0;
  // loads recorded by the edge number that sampled them
  bit            ld_v [8];
  int            ld_e [8];
  logic [DW-1:0] ld_d [8];
  logic          exp_v [ND];
  logic [DW-1:0] exp_d [ND];

  always @(posedge clock or posedge reset) begin
    live = 1'b1;
    if (reset) begin
      m_lc = '0; m_wc = '0; m_ae = 1'b0; m_ic = 1'b0;
      for (int i = 0; i < 8; i++) ld_v[i] = 1'b0;
      for (int d = 0; d < ND; d++) begin exp_v[d] = 1'b0; exp_d[d] = '0; end
    end else begin
      int slot;
      edge_n++;
      if (write_ctrl) begin
        m_wc = (m_wc == 32'hFFFF_FFFF) ? m_wc : m_wc + 1;
        if (write_addr < 256) m_mem[write_addr[7:0]] = write_data;
        else m_ae = 1'b1;
        if (init_en) m_ic = 1'b1;
      end else if (init_en) begin
        if (init_addr < 256) m_mem[init_addr[7:0]] = init_data;
        else m_ae = 1'b1;
      end
      slot = edge_n % 8;
      ld_v[slot] = load_ctrl;
      ld_e[slot] = edge_n;
      if (load_ctrl) begin
        m_lc = (m_lc == 32'hFFFF_FFFF) ? m_lc : m_lc + 1;
        if (load_addr < 256) ld_d[slot] = m_mem[load_addr[7:0]];
        else begin ld_d[slot] = '0; m_ae = 1'b1; end
      end
      // a load sampled at edge e is on the bus after edge e+L-1
      for (int d = 0; d < ND; d++) begin
        int e;
        e = edge_n - d;
        if (e >= 1 && ld_v[e % 8] && ld_e[e % 8] == e) begin
          exp_v[d] = 1'b1;
          exp_d[d] = ld_d[e % 8];
        end else begin
          exp_v[d] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (live) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("L%0d load_valid", d + 1), DW'(dv[d]), DW'(exp_v[d]));
        chk($sformatf("L%0d load_data", d + 1), dd[d], exp_d[d]);
        chk($sformatf("L%0d load_count", d + 1), DW'(dlc[d]), DW'(m_lc));
        chk($sformatf("L%0d write_count", d + 1), DW'(dwc[d]), DW'(m_wc));
        chk($sformatf("L%0d addr_error", d + 1), DW'(dae[d]), DW'(m_ae));
        chk($sformatf("L%0d init_collision", d + 1), DW'(dic[d]), DW'(m_ic));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] lanes(input logic [31:0] v);
    return {16{v}};
  endfunction

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [15:0] rnd_addr();
    int sel;
    sel = $urandom_range(0, 19);
    if (sel == 0) return 16'd255;
    if (sel == 1) return 16'd256;
    if (sel == 2) return 16'($urandom);
    return 16'($urandom_range(0, 255));
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    load_ctrl = 1'b0; write_ctrl = 1'b0; init_en = 1'b0;
  endtask

  logic [DW-1:0] pre5, pre255;
  logic          v1 [6], v3 [6];
  logic [DW-1:0] d1 [6], d3 [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("reset load_valid", DW'(dv[0]), '0);
    chk("reset load_data", dd[1], '0);
    chk("reset load_count", DW'(dlc[2]), '0);
    reset = 1'b0;

    // preload every word
    for (int a = 0; a < 256; a++) begin
      init_en = 1'b1;
      init_addr = 16'(a);
      if (a == 0) init_data = lanes(32'h2);
      else if (a == 1) init_data = lanes(32'h3);
      else if (a == 2) init_data = lanes(32'h4);
      else init_data = rnd512();
      if (a == 5) pre5 = init_data;
      if (a == 255) pre255 = init_data;
      step();
    end
    idle();
    chk("init leaves write_count", DW'(dwc[0]), '0);

    // back-to-back loads of 0,1,2
    for (int j = 0; j < 6; j++) begin
      if (j < 3) begin load_ctrl = 1'b1; load_addr = 16'(j); end
      else load_ctrl = 1'b0;
      step();
      v1[j] = dv[0]; d1[j] = dd[0];
      v3[j] = dv[2]; d3[j] = dd[2];
    end
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("lat1 valid[%0d]", j), DW'(v1[j]), DW'(j < 3));
      chk($sformatf("lat3 valid[%0d]", j), DW'(v3[j]), DW'(j >= 2 && j <= 4));
    end
    chk("lat1 data0", d1[0], lanes(32'h2));
    chk("lat1 data1", d1[1], lanes(32'h3));
    chk("lat1 data held", d1[5], lanes(32'h4));
    chk("lat3 data first", d3[2], lanes(32'h2));
    chk("lat3 data last", d3[4], lanes(32'h4));
    chk("load_count after 3", DW'(dlc[0]), DW'(32'd3));

    // write-first hazard
    write_ctrl = 1'b1; write_addr = 16'd3; write_data = lanes(32'h7);
    load_ctrl = 1'b1; load_addr = 16'd3;
    step();
    idle();
    chk("bypass valid", DW'(dv[0]), DW'(1'b1));
    chk("bypass data", dd[0], lanes(32'h7));
    chk("bypass write_count", DW'(dwc[0]), DW'(32'd1));

    // out-of-range load and write
    load_ctrl = 1'b1; load_addr = 16'h0100;
    write_ctrl = 1'b1; write_addr = 16'hFFFF; write_data = lanes(32'h9);
    step();
    idle();
    chk("oor load valid", DW'(dv[0]), DW'(1'b1));
    chk("oor load data", dd[0], '0);
    chk("oor addr_error", DW'(dae[0]), DW'(1'b1));
    load_ctrl = 1'b1; load_addr = 16'd0;
    step();
    load_addr = 16'd255;
    chk("mem0 untouched", dd[0], lanes(32'h2));
    step();
    idle();
    chk("mem255 untouched", dd[0], pre255);
    chk("addr_error sticky", DW'(dae[0]), DW'(1'b1));

    // init collision
    init_en = 1'b1; init_addr = 16'd5; init_data = lanes(32'hAAAA_0005);
    write_ctrl = 1'b1; write_addr = 16'd6; write_data = lanes(32'hBBBB_0006);
    step();
    idle();
    load_ctrl = 1'b1; load_addr = 16'd6;
    step();
    load_addr = 16'd5;
    chk("collision write kept", dd[0], lanes(32'hBBBB_0006));
    step();
    idle();
    chk("collision init dropped", dd[0], pre5);
    chk("init_collision", DW'(dic[0]), DW'(1'b1));
    chk("collision write_count", DW'(dwc[0]), DW'(32'd3));

    // reset between request and response (LATENCY 2 instance)
    load_ctrl = 1'b1; load_addr = 16'd6;
    step();
    idle();
    reset = 1'b1;
    step();
    chk("reset-mid valid", DW'(dv[1]), '0);
    chk("reset-mid load_count", DW'(dlc[1]), '0);
    chk("reset-mid addr_error", DW'(dae[1]), '0);
    chk("reset-mid init_collision", DW'(dic[1]), '0);
    step();
    reset = 1'b0;
    step();
    chk("post-reset valid", DW'(dv[1]), '0);
    load_ctrl = 1'b1; load_addr = 16'd6;
    step();
    idle();
    step();
    chk("post-reset valid2", DW'(dv[1]), DW'(1'b1));
    chk("memory survives reset", dd[1], lanes(32'hBBBB_0006));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      load_ctrl  = 1'($urandom);
      load_addr  = rnd_addr();
      write_ctrl = ($urandom_range(0, 2) == 0);
      write_addr = rnd_addr();
      write_data = rnd512();
      init_en    = ($urandom_range(0, 3) == 0);
      init_addr  = rnd_addr();
      init_data  = rnd512();
      step();
    end
    reset = 1'b0;
    idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
